fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-side arbiter that lets NUM_REQ producers share the single 8-deep, 8-bit FIFO (test_fifo.fi1) through one write port. Each grant covers a burst of up to MAX_BURST words. The arbiter owns fifo_write and fifo_data_in, and it never asserts fifo_write while fifo_full is high. It sits between the producer agents and the FIFO in the test_fifo environment. The existing FIFO property checker stays bound to the FIFO unchanged.

## Interface
Parameters:
- NUM_REQ, 4: number of producers (2..8)
- fifo_width, 8: data width, must match the FIFO
- MAX_BURST, 4: maximum words per grant (1..8)

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst_  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-producer request; held high while the producer has data
- req_data  in  NUM_REQ x fifo_width  per-producer write data, stable while req is high
- gnt  out  NUM_REQ  one-hot or zero; gnt[i] high = req_data[i] is written this cycle
- fifo_full  in  1  from FIFO
- fifo_write  out  1  to FIFO write strobe
- fifo_data_in  out  fifo_width  to FIFO write data
- busy  out  1  high in GRANT state
- owner  out  $clog2(NUM_REQ)  current or last owner index

## Operation
- FSM states: IDLE and GRANT. Registers: state, owner, last_owner, burst_cnt (width $clog2(MAX_BURST)+1).
- **IDLE**
  - If any req bit is high, the next-state logic picks the first requester at or after last_owner+1 (mod NUM_REQ).
  - owner gets the picked index, burst_cnt gets 0, and the FSM moves to GRANT.
  - If no req bit is high, the FSM stays in IDLE.
- **GRANT**
  - xfer = req[owner] && !fifo_full.
  - gnt[owner] = xfer, combinational. fifo_write = xfer. fifo_data_in = req_data[owner] (a mux in every state; its value is don't-care when fifo_write=0).
  - On xfer, burst_cnt increments.
- **GRANT exit:** the FSM goes to IDLE with last_owner <= owner when either condition holds:
  - !req[owner] (the producer withdrew); or
  - xfer && burst_cnt==MAX_BURST-1 (burst limit reached).
- **fifo_full in GRANT:** no transfer, the grant is kept, and burst_cnt holds. The FSM stays in GRANT while req[owner] is held high.
- Other requesters are never granted while an owner is active. A producer must not drop req in the same cycle as a gnt it expects to use; data is only consumed when gnt is high.
- busy = (state==GRANT).

## Timing
- Reset (rst_ low, asynchronous) values:
  - state=IDLE, owner=0, last_owner=NUM_REQ-1, burst_cnt=0.
  - gnt=0, fifo_write=0, busy=0.
  - Net effect: requester 0 has top priority first after reset.
- Latency: req rising in IDLE gives gnt in the next cycle (one arbitration cycle), provided fifo_full is low.
- Steady burst: one word per cycle, MAX_BURST words, then one IDLE cycle before the next grant.
- Invariants:
  - fifo_write implies !fifo_full.
  - $onehot0(gnt).
  - fifo_write == |gnt.
- Wrap-around: the priority pointer wraps from NUM_REQ-1 to 0.
- Simultaneous events:
  - fifo_full deasserting and the owner dropping req in the same cycle: no write, exit to IDLE.
  - Burst limit hit while other requests are pending: the next owner comes from the round-robin order, not the old owner.
- Reset mid-burst: all outputs drop immediately and asynchronously. A word is written only if fifo_write was high at the edge before reset.

## Structure
- Package fifo_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - default constants FIFO_WIDTH=8, FIFO_DEPTH=8.
- Sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: req and last_owner. Outputs: pick index and pick_valid.
  - Parameterized by NUM_REQ.
- The top module contains the FSM, burst counter and data mux. The existing FIFO instance is connected unchanged.

## Test plan
- **Reset:** drive rst_ low mid-burst with req=4'b0001 -> gnt=0, fifo_write=0, busy=0 immediately. After release with req=4'b1111 -> first grant goes to requester 0.
- **Single producer:** req[2] held high for 6 words with MAX_BURST=4 -> 4 writes, 1 IDLE cycle, then 2 writes. The FIFO reads back the 6 data values in order and cnt=6.
- **Fairness:** req=4'b1111 held with distinct data -> grant order 0,1,2,3,0 in bursts of 4. No requester gets two bursts before all the others get one.
- **Full stall:** fill the FIFO to 8 (fifo_full=1) while req[1] is held -> gnt[1]=0, fifo_write=0, wr_ptr stable, busy=1. After one fifo_read -> exactly one write in the next cycle.
- **Withdraw:** the owner drops req after 2 words -> exit to IDLE. The next pending requester is granted 1 cycle later and burst_cnt restarts at 0.
- **Wrap:** last_owner=3 with req=4'b1001 -> requester 0 is granted before 3.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
package fifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin priority encoder: first requester at or after last_owner+1, wrapping.
// Latency: combinational. Backpressure: none, pure function of req/last_owner.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_owner,
  output logic [$clog2(NUM_REQ)-1:0] pick,
  output logic                       pick_valid
);

  localparam int OW = $clog2(NUM_REQ);

  logic [OW-1:0] idx;

  // Scan from farthest to nearest so the nearest requester after last_owner wins.
  always_comb begin
    pick       = '0;
    pick_valid = |req;
    idx        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = OW'((int'(last_owner) + k) % NUM_REQ);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers in bursts.
// Latency: one arbitration cycle from req to gnt. Backpressure: fifo_full stalls the owner, grant kept.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int fifo_width = FIFO_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ-1:0][fifo_width-1:0]    req_data,
  output logic [NUM_REQ-1:0]                    gnt,
  input  logic                                  fifo_full,
  output logic                                  fifo_write,
  output logic [fifo_width-1:0]                 fifo_data_in,
  output logic                                  busy,
  output logic [$clog2(NUM_REQ)-1:0]            owner
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  arb_state_t    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_owner_q, last_owner_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [OW-1:0] pick;
  logic          pick_valid;
  logic          xfer;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner_q),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  always_comb begin
    xfer         = (state_q == GRANT) && req[owner_q] && !fifo_full;
    gnt          = '0;
    gnt[owner_q] = xfer;
    fifo_write   = xfer;
    fifo_data_in = req_data[owner_q];
    busy         = (state_q == GRANT);
    owner        = owner_q;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = GRANT;
          owner_d     = pick;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer) burst_cnt_d = burst_cnt_q + 1'b1;
        // A stalled owner keeps the grant; only a withdrawal or a full burst releases it.
        if (!req[owner_q] || (xfer && burst_cnt_q == BW'(MAX_BURST - 1))) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule
